// File: rtl/legv8_pkg.sv
// Shared LEGv8 fetch definitions: bus widths, HLT #0 encoding and the fetch FSM states.
package legv8_pkg;
  localparam int ADDR_W = 64;
  localparam int INST_W = 32;

  localparam logic [INST_W-1:0] HLT_INST = 32'hD440_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: redirect and enable from the core, the instruction-memory port and the IF/ID outputs to decode.
interface if_stage_if;
  import legv8_pkg::*;

  logic              FETCH_EN;
  logic              BR_TAKEN;
  logic [ADDR_W-1:0] BR_TARGET;
  logic [ADDR_W-1:0] INST_ADDR;
  logic [INST_W-1:0] INSTRUCTION;
  logic              ID_READY;
  logic              IFID_VALID;
  logic [ADDR_W-1:0] IFID_PC;
  logic [INST_W-1:0] IFID_INST;
  logic              HALTED;
  logic              FAULT;
  logic [31:0]       FETCH_CNT;

  modport master (
    output FETCH_EN, BR_TAKEN, BR_TARGET, INSTRUCTION, ID_READY,
    input  INST_ADDR, IFID_VALID, IFID_PC, IFID_INST, HALTED, FAULT, FETCH_CNT
  );

  modport slave (
    input  FETCH_EN, BR_TAKEN, BR_TARGET, INSTRUCTION, ID_READY,
    output INST_ADDR, IFID_VALID, IFID_PC, IFID_INST, HALTED, FAULT, FETCH_CNT
  );
endinterface

// File: rtl/ifid_reg.sv
// IF/ID holding register: flush beats load, an accepted entry drains, otherwise holds.
// One cycle from load to outputs; a held entry stays put while ready is low.
module ifid_reg
  import legv8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              ready,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic [INST_W-1:0] new_inst,
  output logic              valid,
  output logic [ADDR_W-1:0] pc,
  output logic [INST_W-1:0] inst
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= new_pc;
      inst  <= new_inst;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction fetch: owns the PC, drives the combinational instruction memory, fills IF/ID.
// Instruction reaches IF/ID one cycle after INST_ADDR; decode back-pressure holds both PC and IF/ID.
module if_stage
  import legv8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [INST_W-1:0] HALT_INST  = HLT_INST,
  parameter int                IMEM_BYTES = 32
) (
  input  logic      CLK,
  input  logic      RST_N,
  if_stage_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = 64'(IMEM_BYTES) - 64'd4;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              fault;
  logic [31:0]       fetch_cnt;

  logic slot_free;
  logic out_of_range;
  logic load;

  assign slot_free    = !bus.IFID_VALID || bus.ID_READY;
  assign out_of_range = pc > LAST_ADDR;
  assign load         = (state == RUN) && bus.FETCH_EN && !bus.BR_TAKEN
                        && !out_of_range && slot_free;

  // Redirect outranks everything; a misaligned target is a fault, not a silent truncation.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      fault     <= 1'b0;
      fetch_cnt <= '0;
    end else if (bus.BR_TAKEN) begin
      pc <= {bus.BR_TARGET[ADDR_W-1:2], 2'b00};
      if (bus.BR_TARGET[1:0] != 2'b00) begin
        fault <= 1'b1;
        state <= HALT;
      end else begin
        state <= bus.FETCH_EN ? RUN : IDLE;
      end
    end else begin
      case (state)
        IDLE: if (bus.FETCH_EN) state <= RUN;
        RUN: begin
          if (!bus.FETCH_EN) begin
            state <= IDLE;
          end else if (out_of_range) begin
            fault <= 1'b1;
            state <= HALT;
          end else if (load) begin
            pc <= pc + 64'd4;
            if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
            if (bus.INSTRUCTION == HALT_INST) state <= HALT;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk      (CLK),
    .rst_n    (RST_N),
    .flush    (bus.BR_TAKEN),
    .load     (load),
    .ready    (bus.ID_READY),
    .new_pc   (pc),
    .new_inst (bus.INSTRUCTION),
    .valid    (bus.IFID_VALID),
    .pc       (bus.IFID_PC),
    .inst     (bus.IFID_INST)
  );

  assign bus.INST_ADDR = pc;
  assign bus.HALTED    = (state == HALT);
  assign bus.FAULT     = fault;
  assign bus.FETCH_CNT = fetch_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a 32-byte combinational instruction memory.
module tb_if_stage;
  import legv8_pkg::*;

  logic CLK = 1'b0;
  logic RST_N;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] mem [8];

  if_stage_if bus ();

  if_stage #(.RESET_PC(64'h0), .HALT_INST(32'hD440_0000), .IMEM_BYTES(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    if (bus.INST_ADDR < 64'd32) bus.INSTRUCTION = mem[bus.INST_ADDR[4:2]];
    else                        bus.INSTRUCTION = 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Pulse reset between edges, leaving the DUT in IDLE before the next rising edge.
  task automatic restart();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
  endtask

  task automatic fill_addi();
    for (int i = 0; i < 8; i++) mem[i] = 32'h9100_0400 + 32'(i);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_addi();
    RST_N         = 1'b0;
    bus.FETCH_EN  = 1'b1;
    bus.BR_TAKEN  = 1'b0;
    bus.BR_TARGET = '0;
    bus.ID_READY  = 1'b1;
    #2;
    check("rst_addr",  bus.INST_ADDR, 64'h0);
    check("rst_valid", 64'(bus.IFID_VALID), 64'h0);
    check("rst_ifpc",  bus.IFID_PC, 64'h0);
    check("rst_inst",  64'(bus.IFID_INST), 64'h0);
    check("rst_halt",  64'(bus.HALTED), 64'h0);
    check("rst_fault", 64'(bus.FAULT), 64'h0);
    check("rst_cnt",   64'(bus.FETCH_CNT), 64'h0);
    tick();
    RST_N = 1'b1;

    // 1: straight-line fetch
    tick();
    check("seq_idle_addr",  bus.INST_ADDR, 64'h0);
    check("seq_idle_valid", 64'(bus.IFID_VALID), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("seq_addr",  bus.INST_ADDR, 64'(4 * (i + 1)));
      check("seq_ifpc",  bus.IFID_PC, 64'(4 * i));
      check("seq_inst",  64'(bus.IFID_INST), 64'(32'h9100_0400 + 32'(i)));
      check("seq_valid", 64'(bus.IFID_VALID), 64'h1);
    end
    check("seq_cnt", 64'(bus.FETCH_CNT), 64'd4);

    // 2: back-pressure at IFID_PC 0x4
    restart();
    tick();
    tick();
    tick();
    check("bp_pre_ifpc", bus.IFID_PC, 64'h4);
    bus.ID_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_ifpc", bus.IFID_PC, 64'h4);
      check("bp_hold_inst", 64'(bus.IFID_INST), 64'h9100_0401);
      check("bp_hold_addr", bus.INST_ADDR, 64'h8);
    end
    bus.ID_READY = 1'b1;
    tick();
    check("bp_resume_ifpc", bus.IFID_PC, 64'h8);
    check("bp_resume_addr", bus.INST_ADDR, 64'hC);
    check("bp_resume_cnt",  64'(bus.FETCH_CNT), 64'd3);

    // 3: redirect while a stalled entry is held
    restart();
    tick();
    tick();
    bus.ID_READY = 1'b0;
    tick();
    check("br_pre_valid", 64'(bus.IFID_VALID), 64'h1);
    bus.BR_TAKEN  = 1'b1;
    bus.BR_TARGET = 64'h10;
    tick();
    bus.BR_TAKEN = 1'b0;
    check("br_flush_valid", 64'(bus.IFID_VALID), 64'h0);
    check("br_addr",        bus.INST_ADDR, 64'h10);
    tick();
    check("br_tgt_ifpc",  bus.IFID_PC, 64'h10);
    check("br_tgt_valid", 64'(bus.IFID_VALID), 64'h1);
    check("br_cnt",       64'(bus.FETCH_CNT), 64'd2);
    bus.ID_READY = 1'b1;

    // 4: HLT at 0x8
    mem[2] = 32'hD440_0000;
    restart();
    tick();
    tick();
    tick();
    tick();
    check("hlt_inst",   64'(bus.IFID_INST), 64'hD440_0000);
    check("hlt_ifpc",   bus.IFID_PC, 64'h8);
    check("hlt_halted", 64'(bus.HALTED), 64'h1);
    check("hlt_addr",   bus.INST_ADDR, 64'hC);
    tick();
    tick();
    check("hlt_stay_addr",  bus.INST_ADDR, 64'hC);
    check("hlt_drain",      64'(bus.IFID_VALID), 64'h0);
    check("hlt_cnt",        64'(bus.FETCH_CNT), 64'd3);
    bus.BR_TAKEN  = 1'b1;
    bus.BR_TARGET = 64'h0;
    tick();
    bus.BR_TAKEN = 1'b0;
    check("hlt_exit_halted", 64'(bus.HALTED), 64'h0);
    check("hlt_exit_addr",   bus.INST_ADDR, 64'h0);
    tick();
    check("hlt_rerun_ifpc",  bus.IFID_PC, 64'h0);
    check("hlt_rerun_valid", 64'(bus.IFID_VALID), 64'h1);
    fill_addi();

    // 5a: misaligned redirect
    restart();
    tick();
    tick();
    bus.BR_TAKEN  = 1'b1;
    bus.BR_TARGET = 64'h6;
    tick();
    bus.BR_TAKEN = 1'b0;
    check("mis_fault",  64'(bus.FAULT), 64'h1);
    check("mis_halted", 64'(bus.HALTED), 64'h1);
    check("mis_addr",   bus.INST_ADDR, 64'h4);
    check("mis_valid",  64'(bus.IFID_VALID), 64'h0);
    tick();
    check("mis_stay_addr", bus.INST_ADDR, 64'h4);

    // 5b: running off the end of memory
    restart();
    check("oor_fault_cleared", 64'(bus.FAULT), 64'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      check("oor_ifpc", bus.IFID_PC, 64'(4 * i));
    end
    check("oor_pre_fault", 64'(bus.FAULT), 64'h0);
    tick();
    check("oor_fault",  64'(bus.FAULT), 64'h1);
    check("oor_halted", 64'(bus.HALTED), 64'h1);
    check("oor_ifpc",   bus.IFID_PC, 64'h1C);
    check("oor_addr",   bus.INST_ADDR, 64'h20);
    check("oor_cnt",    64'(bus.FETCH_CNT), 64'd8);

    // 6: asynchronous reset between edges
    restart();
    tick();
    tick();
    tick();
    tick();
    check("ar_pre_cnt", 64'(bus.FETCH_CNT), 64'd3);
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_addr",  bus.INST_ADDR, 64'h0);
    check("ar_valid", 64'(bus.IFID_VALID), 64'h0);
    check("ar_cnt",   64'(bus.FETCH_CNT), 64'h0);
    check("ar_ifpc",  bus.IFID_PC, 64'h0);
    RST_N = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
